// File: rtl/rv_pkg.sv
// Shared definitions for the simplified RISC-V core: opcodes, NOP encoding,
// instruction field positions and the fetch state encoding.
package rv_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_REQ   = 2'd0;
    localparam fetch_state_t FETCH_WAIT  = 2'd1;
    localparam fetch_state_t FETCH_HOLD  = 2'd2;
    localparam fetch_state_t FETCH_DRAIN = 2'd3;

endpackage

// File: rtl/inst_fields.sv
// Combinational slicer splitting a 32-bit RISC-V instruction into its
// standard fields; shared between fetch and the control unit.
module inst_fields
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7
);

    assign opcode = instr[OPCODE_LSB +: 7];
    assign rd     = instr[RD_LSB     +: 5];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign rs1    = instr[RS1_LSB    +: 5];
    assign rs2    = instr[RS2_LSB    +: 5];
    assign funct7 = instr[FUNCT7_LSB +: 7];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word read in flight and
// hands decoded-field instructions to the control unit over valid/ready.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            reset,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [6:0]      id_funct7
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Outputs are gated during the reset cycle since the state register
    // only clears on the edge.
    assign imem_req_valid = !reset && (state == FETCH_REQ);
    assign imem_req_addr  = pc;
    assign id_valid       = !reset && (state == FETCH_HOLD);

    // A redirect always wins; DRAIN exists solely to swallow the response of
    // a request that was accepted before the redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_REQ;
            pc       <= RESET_PC;
            id_pc    <= RESET_PC;
            id_instr <= INSTR_NOP;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= imem_req_ready ? FETCH_DRAIN : FETCH_REQ;
                    end else if (imem_req_ready) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= imem_rsp_valid ? FETCH_REQ : FETCH_DRAIN;
                    end else if (imem_rsp_valid) begin
                        id_instr <= imem_rsp_data;
                        id_pc    <= pc;
                        pc       <= pc + XLEN'(4);
                        state    <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= FETCH_REQ;
                    end else if (id_ready) begin
                        state <= FETCH_REQ;
                    end
                end
                FETCH_DRAIN: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (imem_rsp_valid) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

    inst_fields u_fields (
        .instr  (id_instr),
        .opcode (id_opcode),
        .rd     (id_rd),
        .funct3 (id_funct3),
        .rs1    (id_rs1),
        .rs2    (id_rs2),
        .funct7 (id_funct7)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all judged against an address-level model of the fetch stream.
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rd          (id_rd),
        .id_funct3      (id_funct3),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_funct7      (id_funct7)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the PC of the next instruction the control unit
    // should see, plus a single-slot memory with random latency.
    logic [31:0] exp_pc;
    bit          pending;
    logic [31:0] pend_addr;
    int          countdown;
    bit          prev_redirect;
    bit          prev_stall;
    int          deliveries;

    int          knob_req_ready;
    int          knob_id_ready;
    int          lat_min;
    int          lat_max;
    int          redirect_pct;
    bit          knob_redirect;
    logic [31:0] knob_redirect_pc;

    int          used;
    int          deliv_before;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h00B5_0533;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus();
        if (knob_req_ready < 0) imem_req_ready = ($urandom_range(0, 99) < 70);
        else                    imem_req_ready = (knob_req_ready != 0);
        if (knob_id_ready < 0)  id_ready = ($urandom_range(0, 99) < 60);
        else                    id_ready = (knob_id_ready != 0);
        if (pending && countdown == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (knob_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = knob_redirect_pc;
            knob_redirect  = 1'b0;
        end else if (redirect_pct > 0 && $urandom_range(0, 99) < redirect_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    task automatic model_update();
        if (imem_req_valid && imem_req_ready) begin
            check("single_outstanding", 32'(pending), 32'd0);
            pending   = 1'b1;
            pend_addr = imem_req_addr;
            countdown = $urandom_range(lat_min, lat_max);
        end else if (imem_rsp_valid) begin
            pending = 1'b0;
        end else if (pending) begin
            countdown--;
        end
        if (reset) begin
            exp_pc        = RST_PC;
            prev_redirect = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (id_valid && id_ready) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_redirect = redirect_valid;
            prev_stall    = imem_req_valid && !imem_req_ready && !redirect_valid;
        end
    endtask

    task automatic check_output();
        logic [31:0] w;
        if (reset) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_id_valid", 32'(id_valid), 32'd0);
            check("rst_id_instr", id_instr, INSTR_NOP);
            check("rst_id_pc", id_pc, RST_PC);
        end else begin
            if (prev_redirect) check("id_valid_after_redirect", 32'(id_valid), 32'd0);
            if (prev_stall)    check("req_valid_held", 32'(imem_req_valid), 32'd1);
            if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
            if (id_valid) begin
                w = mem_word(exp_pc);
                check("no_req_while_hold", 32'(imem_req_valid), 32'd0);
                check("id_pc", id_pc, exp_pc);
                check("id_instr", id_instr, w);
                check("id_opcode", 32'(id_opcode), 32'(w[6:0]));
                check("id_rd", 32'(id_rd), 32'(w[11:7]));
                check("id_funct3", 32'(id_funct3), 32'(w[14:12]));
                check("id_rs1", 32'(id_rs1), 32'(w[19:15]));
                check("id_rs2", 32'(id_rs2), 32'(w[24:20]));
                check("id_funct7", 32'(id_funct7), 32'(w[31:25]));
            end
        end
    endtask

    task automatic cycle();
        apply_stimulus();
        #1;
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_output();
    endtask

    task automatic wait_id_valid(input int max_cycles, output int n);
        n = 0;
        while (!id_valid && n < max_cycles) begin
            cycle();
            n++;
        end
        check("wait_id_valid", 32'(id_valid), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        imem_req_ready   = 1'b0;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        id_ready         = 1'b0;
        exp_pc           = RST_PC;
        pending          = 1'b0;
        pend_addr        = '0;
        countdown        = 0;
        prev_redirect    = 1'b0;
        prev_stall       = 1'b0;
        deliveries       = 0;
        knob_req_ready   = 0;
        knob_id_ready    = 0;
        lat_min          = 0;
        lat_max          = 0;
        redirect_pct     = 0;
        knob_redirect    = 1'b0;
        knob_redirect_pc = '0;

        cycle();
        cycle();

        // Zero-wait memory: first instruction visible after REQ and WAIT.
        reset = 1'b0;
        knob_req_ready = 1;
        wait_id_valid(10, used);
        check("t1_cycles_to_valid", used, 32'd2);
        check("t1_id_pc", id_pc, 32'h0000_0100);
        check("t1_id_instr", id_instr, 32'h00B5_0533);
        check("t1_opcode", 32'(id_opcode), 32'h33);
        check("t1_funct3", 32'(id_funct3), 32'd0);
        check("t1_funct7", 32'(id_funct7), 32'd0);
        check("t1_rd", 32'(id_rd), 32'd10);
        check("t1_rs1", 32'(id_rs1), 32'd10);
        check("t1_rs2", 32'(id_rs2), 32'd11);

        // Backpressure from the control unit.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_valid", 32'(id_valid), 32'd1);
            check("t2_hold_pc", id_pc, 32'h0000_0100);
            check("t2_hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        knob_id_ready = 1;
        cycle();
        knob_id_ready = 0;
        check("t2_next_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_next_req_addr", imem_req_addr, 32'h0000_0104);

        // Redirect during WAIT; the stale response arrives two cycles later.
        lat_min = 2;
        lat_max = 2;
        cycle();
        knob_redirect    = 1'b1;
        knob_redirect_pc = 32'h0000_0203;
        cycle();
        for (int i = 0; i < 10 && !imem_req_valid; i++) begin
            check("t3_drain_no_valid", 32'(id_valid), 32'd0);
            cycle();
        end
        check("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_req_addr", imem_req_addr, 32'h0000_0200);
        check("t3_no_valid", 32'(id_valid), 32'd0);

        // Redirect coinciding with the response.
        lat_min = 0;
        lat_max = 0;
        cycle();
        knob_redirect    = 1'b1;
        knob_redirect_pc = 32'h0000_0300;
        cycle();
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h0000_0300);
        check("t4_no_valid", 32'(id_valid), 32'd0);
        knob_req_ready = 0;
        cycle();
        check("t4_no_valid_later", 32'(id_valid), 32'd0);

        // PC wrap at the top of the address space.
        knob_redirect    = 1'b1;
        knob_redirect_pc = 32'hFFFF_FFFE;
        cycle();
        check("t5_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        knob_req_ready = 1;
        wait_id_valid(10, used);
        check("t5_id_pc", id_pc, 32'hFFFF_FFFC);
        knob_id_ready = 1;
        cycle();
        knob_id_ready = 0;
        check("t5_wrap_valid", 32'(imem_req_valid), 32'd1);
        check("t5_wrap_addr", imem_req_addr, 32'h0000_0000);

        // Reset while a fetch is in flight; its response lands in REQ.
        lat_min = 3;
        lat_max = 3;
        cycle();
        reset = 1'b1;
        knob_req_ready = 0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10 && pending; i++) begin
            cycle();
            check("t6_no_valid", 32'(id_valid), 32'd0);
            check("t6_req_addr", imem_req_addr, RST_PC);
        end
        cycle();
        check("t6_stale_ignored", 32'(id_valid), 32'd0);
        lat_min = 0;
        lat_max = 0;
        knob_req_ready = 1;
        wait_id_valid(10, used);
        check("t6_id_pc", id_pc, RST_PC);
        check("t6_id_instr", id_instr, 32'h00B5_0533);
        knob_id_ready = 1;
        cycle();

        // Random traffic with redirects and variable memory latency.
        knob_req_ready = -1;
        knob_id_ready  = -1;
        lat_min        = 0;
        lat_max        = 3;
        redirect_pct   = 5;
        deliv_before   = deliveries;
        repeat (3000) cycle();
        check("random_progress", 32'((deliveries - deliv_before) > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
